// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by both the master and the slave register file.
package axi4_lite_pkg;

  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  // Merge new write data into an existing word, one byte lane per strobe bit.
  function automatic logic [AXIL_DATA_W-1:0] apply_wstrb(
    input logic [AXIL_DATA_W-1:0] old_word,
    input logic [AXIL_DATA_W-1:0] data,
    input logic [AXIL_STRB_W-1:0] strb
  );
    logic [AXIL_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < AXIL_STRB_W; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = data[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers. Write address and write
// data are captured independently in holding registers and committed together
// one edge later; reads return the register value seen at the address
// handshake. Every output is registered or derived from internal state only.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // An address is in range only when every bit above the register index is zero;
  // the two byte-offset bits are deliberately ignored.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> (2 + IDX_W)) == '0;
  endfunction

  logic [AXIL_DATA_W-1:0] regs [NUM_REGS];

  // Write path holding state: decoded address, data and strobes.
  logic              aw_held;
  logic [IDX_W-1:0]  aw_idx;
  logic              aw_ok;
  logic              w_held;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic              bvalid;
  resp_t             bresp;

  // Read path response state.
  logic              rvalid;
  logic [31:0]       rdata;
  resp_t             rresp;

  logic              aw_fire;
  logic              w_fire;
  logic              ar_fire;
  logic              commit;
  logic [IDX_W-1:0]  ar_idx;
  logic              ar_ok;

  assign S_AXI_AWREADY = !aw_held && !bvalid;
  assign S_AXI_WREADY  = !w_held && !bvalid;
  assign S_AXI_ARREADY = !rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

  assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit  = aw_held && w_held && !bvalid;
  assign ar_idx  = S_AXI_ARADDR[2 +: IDX_W];
  assign ar_ok   = addr_in_range(S_AXI_ARADDR);

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_out[32*g +: 32] = regs[g];
    end
  endgenerate

  // Capture AW and W independently, then commit both together and raise the B response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      aw_idx  <= '0;
      aw_ok   <= 1'b0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[2 +: IDX_W];
        aw_ok   <= addr_in_range(S_AXI_AWADDR);
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Update the addressed register on an in-range commit and pulse its strobe for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit && aw_ok) begin
        regs[aw_idx]     <= apply_wstrb(regs[aw_idx], w_data, w_strb);
        wr_pulse[aw_idx] <= 1'b1;
      end
    end
  end

  // Sample the register at the AR handshake and hold the response until R is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      if (ar_fire) begin
        rvalid <= 1'b1;
        if (ar_ok) begin
          rdata <= regs[ar_idx];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axi4_lite_slave_regfile.md
Name: axi4_lite_slave_regfile

Overview:
AXI4-Lite slave exposing a bank of 32-bit control/status registers. It is the downstream endpoint for transactions issued by the team's AXI4-Lite master on the same 32-bit bus. Register contents and per-register write pulses are exported to the surrounding fabric. Independent write and read paths; one outstanding transaction per path.

Parameters:
NUM_REGS, 16, number of 32-bit registers; power of two, 2..256.
ADDR_W, 32, width of AWADDR/ARADDR.
IDX_W, $clog2(NUM_REGS), derived register-index width; not overridden.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables; bit i gates byte i
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  NUM_REGS*32  flat register contents; reg i = bits [32*i+:32]
wr_pulse  out  NUM_REGS  one-cycle pulse on the commit cycle of a successful write to reg i

Behaviour:
- Reset (async): all registers 0, aw_held=w_held=0, BVALID=0, RVALID=0, BRESP=RRESP=00, RDATA=0, wr_pulse=0. AWREADY, WREADY and ARREADY read 1 after reset.
- Decode: index = addr[2+:IDX_W]. addr[1:0] is ignored (unaligned is treated as aligned). Address is out of range when addr[ADDR_W-1:2+IDX_W] != 0.
- Write address capture: AWREADY = !aw_held && !BVALID. On AWVALID&&AWREADY, latch the address and set aw_held.
- Write data capture: WREADY = !w_held && !BVALID. On WVALID&&WREADY, latch WDATA/WSTRB and set w_held.
- AW and W arrive in either order or in the same cycle. No ordering dependency between them.
- Commit occurs on the first edge where aw_held && w_held && !BVALID:
  - in range: byte i of the register is updated where WSTRB[i]=1; wr_pulse[index]=1 for that cycle; BRESP=00 (OKAY).
  - out of range: no register change; no pulse; BRESP=10 (SLVERR).
  - on the same edge, BVALID<=1 and aw_held, w_held <= 0.
- Latency: AW and W handshakes on edge k give commit and BVALID on edge k+1. The updated value is visible on reg_out after edge k+1.
- B channel: BVALID and BRESP hold stable until BVALID&&BREADY, then BVALID<=0. While BVALID=1 no new AW or W is accepted. A new AW/W can be accepted in the cycle after the B handshake.
- Read: ARREADY = !RVALID. On ARVALID&&ARREADY, the next edge sets RVALID=1 with:
  - in range: RDATA = register value sampled at the handshake edge (pre-commit), RRESP=00.
  - out of range: RDATA = 0, RRESP=10.
- R channel: RDATA and RRESP hold stable until RVALID&&RREADY. Back-to-back reads reach at most one per 2 cycles.
- Simultaneous write commit and read handshake to the same register on the same edge: the read returns the old value. A later read returns the new value.
- The write and read paths are fully independent and may both be active each cycle.
- Outputs never depend combinationally on *VALID/*READY inputs. READY outputs are functions of internal state only.
- Reset asserted mid-transaction: all held requests and pending responses are discarded and registers clear to 0. The master is expected to be reset together with this block.

Decomposition:
- Shared package axi4_lite_pkg:
  - resp_t (2-bit enum: RESP_OKAY=2'b00, RESP_SLVERR=2'b10), shared with the master.
  - constant AXIL_DATA_W=32, AXIL_STRB_W=4.
  - function apply_wstrb(old, data, strb) returning the byte-merged 32-bit word.
- No sub-module: both channel paths are small and live in one module.

Test Plan:
- Reset, then AW(0x08) and W(0xDEADBEEF, strb 1111) in the same cycle -> commit next edge; BVALID=1, BRESP=00; reg2=0xDEADBEEF; wr_pulse[2] high for one cycle.
- W(0x11223344) 3 cycles before AW(0x04), BREADY low 4 cycles -> WREADY drops after W; BVALID held stable 4 cycles; AWREADY/WREADY stay 0 until the B handshake; reg1=0x11223344.
- reg3=0xAABBCCDD, write 0x00000011 strb 0001 -> reg3=0xAABBCC11. Read 0x0C -> RDATA=0xAABBCC11, RRESP=00.
- Write to 0x40 and read 0x1000 (NUM_REGS=16) -> BRESP=10, no reg change, no wr_pulse; RDATA=0, RRESP=10.
- Read of reg5 handshake on the same edge as a commit of 0x5 to reg5 (old 0) -> RDATA=0. A following read returns 0x5. RVALID held with RREADY low; ARREADY=0 meanwhile.
- Assert rst while BVALID=1 and a read is pending -> BVALID=RVALID=0 immediately; reg_out=0; all READYs 1 after release.
